vgac_pipe: RTL and testbench

Parametrised VGA/DVI timing generator and pixel output stage, the successor to the fixed-mode `vgac` controller. It issues pixel addresses ahead of the visible pixel so that a framebuffer or sprite compositor with a known read latency can supply colour data. It then delays sync and data-enable so they stay cycle-aligned with that data. It sits between the display-clock pixel source and the board VGA pins.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vgac_pipe.sv | 125 ++++++++++++
 tb/tb_vgac_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets, sync polarities and the pixel address width.
// Imported by the timing generator and anything that consumes its addresses.
package vga_timing_pkg;

   localparam int ADDR_W = 11;

   typedef struct packed {
      logic [11:0] h_active;
      logic [11:0] h_front;
      logic [11:0] h_pulse;
      logic [11:0] h_back;
      logic [11:0] v_active;
      logic [11:0] v_front;
      logic [11:0] v_pulse;
      logic [11:0] v_back;
      logic        hs_pol;
      logic        vs_pol;
   } vga_mode_t;

   localparam vga_mode_t MODE_640X480_60 = '{
      h_active: 12'd640,  h_front: 12'd16,  h_pulse: 12'd96, h_back: 12'd48,
      v_active: 12'd480,  v_front: 12'd10,  v_pulse: 12'd2,  v_back: 12'd33,
      hs_pol: 1'b0, vs_pol: 1'b0};

   localparam vga_mode_t MODE_800X600_60 = '{
      h_active: 12'd800,  h_front: 12'd40,  h_pulse: 12'd128, h_back: 12'd88,
      v_active: 12'd600,  v_front: 12'd1,   v_pulse: 12'd4,   v_back: 12'd23,
      hs_pol: 1'b1, vs_pol: 1'b1};

   localparam vga_mode_t MODE_1280X720_60 = '{
      h_active: 12'd1280, h_front: 12'd110, h_pulse: 12'd40, h_back: 12'd220,
      v_active: 12'd720,  v_front: 12'd5,   v_pulse: 12'd5,  v_back: 12'd20,
      hs_pol: 1'b1, vs_pol: 1'b1};

   function automatic logic [11:0] h_whole(input vga_mode_t m);
      return m.h_active + m.h_front + m.h_pulse + m.h_back;
   endfunction

   function automatic logic [11:0] v_whole(input vga_mode_t m);
      return m.v_active + m.v_front + m.v_pulse + m.v_back;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-clear shift register of DEPTH stages; collapses to a plain wire at DEPTH=0.
// Keeps control bits aligned with data coming back from a fixed-latency source.
module vga_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q_o = d_i;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vgac_pipe.sv
// Parametrised VGA/DVI timing generator: issues pixel addresses FETCH_LAT clocks
// ahead and realigns sync/de with the returned pixel data in one output register.
module vgac_pipe
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int H_FRONT   = 16,
   parameter int H_PULSE   = 96,
   parameter int H_BACK    = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FRONT   = 10,
   parameter int V_PULSE   = 2,
   parameter int V_BACK    = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int FETCH_LAT = 1,
   parameter int COLOR_W   = 4
) (
   input  logic                   vga_clk,
   input  logic                   clrn,
   input  logic [3*COLOR_W-1:0]   d_in,
   output logic [ADDR_W-1:0]      col_addr,
   output logic [ADDR_W-1:0]      row_addr,
   output logic                   line_start,
   output logic                   frame_start,
   output logic                   hs,
   output logic                   vs,
   output logic                   de,
   output logic [COLOR_W-1:0]     r,
   output logic [COLOR_W-1:0]     g,
   output logic [COLOR_W-1:0]     b
);

   localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC0_C = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] H_SYNC1_C = 12'(H_ACTIVE + H_FRONT + H_PULSE);
   localparam logic [11:0] H_LAST_C  = 12'(H_ACTIVE + H_FRONT + H_PULSE + H_BACK - 1);
   localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC0_C = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] V_SYNC1_C = 12'(V_ACTIVE + V_FRONT + V_PULSE);
   localparam logic [11:0] V_LAST_C  = 12'(V_ACTIVE + V_FRONT + V_PULSE + V_BACK - 1);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;

   logic h_act, v_act, fetch_act, hs_act, vs_act;
   logic [2:0] raw_ctl, dly_ctl;

   logic                 de_q, de_d;
   logic                 hs_q, hs_d;
   logic                 vs_q, vs_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;

   // v_cnt only moves on the line wrap, so both hit 0 on the same edge at frame end.
   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST_C) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST_C) ? 12'd0 : v_cnt_q + 12'd1;
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_act     = (h_cnt_q < H_ACT_C);
   assign v_act     = (v_cnt_q < V_ACT_C);
   assign fetch_act = h_act && v_act;
   assign hs_act    = (h_cnt_q >= H_SYNC0_C) && (h_cnt_q < H_SYNC1_C);
   assign vs_act    = (v_cnt_q >= V_SYNC0_C) && (v_cnt_q < V_SYNC1_C);

   assign col_addr    = fetch_act ? h_cnt_q[ADDR_W-1:0] : ADDR_W'(H_ACTIVE);
   assign row_addr    = fetch_act ? v_cnt_q[ADDR_W-1:0] : ADDR_W'(V_ACTIVE);
   assign line_start  = (h_cnt_q == 12'd0);
   assign frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

   assign raw_ctl = {fetch_act, hs_act, vs_act};

   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (FETCH_LAT)
   ) u_ctl_dly (
      .clk   (vga_clk),
      .rst_n (clrn),
      .d_i   (raw_ctl),
      .q_o   (dly_ctl)
   );

   always_comb begin
      de_d  = dly_ctl[2];
      hs_d  = dly_ctl[1] ? HS_POL : ~HS_POL;
      vs_d  = dly_ctl[0] ? VS_POL : ~VS_POL;
      rgb_d = dly_ctl[2] ? d_in : '0;
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         de_q  <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         rgb_q <= '0;
      end else begin
         de_q  <= de_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         rgb_q <= rgb_d;
      end
   end

   assign de = de_q;
   assign hs = hs_q;
   assign vs = vs_q;
   assign r  = rgb_q[COLOR_W-1:0];
   assign g  = rgb_q[2*COLOR_W-1:COLOR_W];
   assign b  = rgb_q[3*COLOR_W-1:2*COLOR_W];

endmodule

// File: tb/tb_vgac_pipe.sv
// Scoreboard bench for vgac_pipe in a tiny 15x8 mode: FETCH_LAT=1, FETCH_LAT=3
// and inverted-polarity instances share one clock and one reset.
module tb_vgac_pipe;

   localparam int HA = 8, HF = 2, HP = 3, HB = 2;
   localparam int VA = 4, VF = 1, VP = 2, VB = 1;
   localparam int HW = HA + HF + HP + HB;
   localparam int VW = VA + VF + VP + VB;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   logic [10:0] col_a, row_a, col_b, row_b, col_c, row_c;
   logic        ls_a, fs_a, hs_a, vs_a, de_a;
   logic        ls_b, fs_b, hs_b, vs_b, de_b;
   logic        ls_c, fs_c, hs_c, vs_c, de_c;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
   logic [11:0] din_a, din_b, din_c, sb1, sb2;

   vgac_pipe #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
               .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LAT(1), .COLOR_W(4)) u_dut_a (
      .vga_clk(clk), .clrn(clrn), .d_in(din_a), .col_addr(col_a), .row_addr(row_a),
      .line_start(ls_a), .frame_start(fs_a), .hs(hs_a), .vs(vs_a), .de(de_a),
      .r(r_a), .g(g_a), .b(b_a));

   vgac_pipe #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
               .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LAT(3), .COLOR_W(4)) u_dut_b (
      .vga_clk(clk), .clrn(clrn), .d_in(din_b), .col_addr(col_b), .row_addr(row_b),
      .line_start(ls_b), .frame_start(fs_b), .hs(hs_b), .vs(vs_b), .de(de_b),
      .r(r_b), .g(g_b), .b(b_b));

   vgac_pipe #(.H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
               .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(1), .COLOR_W(4)) u_dut_c (
      .vga_clk(clk), .clrn(clrn), .d_in(din_c), .col_addr(col_c), .row_addr(row_c),
      .line_start(ls_c), .frame_start(fs_c), .hs(hs_c), .vs(vs_c), .de(de_c),
      .r(r_c), .g(g_c), .b(b_c));

   // Pixel sources: {b,g,r} = {col,row,col}, with 1 or 3 clocks of read latency.
   always @(posedge clk) begin
      din_a <= {col_a[3:0], row_a[3:0], col_a[3:0]};
      din_c <= {col_c[3:0], row_c[3:0], col_c[3:0]};
      sb1   <= {col_b[3:0], row_b[3:0], col_b[3:0]};
      sb2   <= sb1;
      din_b <= sb2;
   end

   logic [10:0] obs_col, obs_row;
   logic        obs_ls, obs_fs, obs_hs, obs_vs, obs_de;
   logic [11:0] obs_rgb;

   always_comb begin
      obs_col = col_a; obs_row = row_a; obs_ls = ls_a; obs_fs = fs_a;
      obs_hs = hs_a; obs_vs = vs_a; obs_de = de_a; obs_rgb = {b_a, g_a, r_a};
      if (sel == 1) begin
         obs_col = col_b; obs_row = row_b; obs_ls = ls_b; obs_fs = fs_b;
         obs_hs = hs_b; obs_vs = vs_b; obs_de = de_b; obs_rgb = {b_b, g_b, r_b};
      end else if (sel == 2) begin
         obs_col = col_c; obs_row = row_c; obs_ls = ls_c; obs_fs = fs_c;
         obs_hs = hs_c; obs_vs = vs_c; obs_de = de_c; obs_rgb = {b_c, g_c, r_c};
      end
   end

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
   } exp_t;

   exp_t exp_q[$];

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (3) @(posedge clk);
      #1 clrn = 1'b1;
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({hs_a, vs_a, de_a, r_a, g_a, b_a} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
         bad++;
         $display("FAIL reset_out_a: got hs/vs/de/rgb=%b%b%b %h, want 110 000", hs_a, vs_a, de_a, {b_a, g_a, r_a});
      end
      total++;
      if ({col_a, row_a, ls_a, fs_a} !== {11'd0, 11'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL reset_fetch_a: got col=%0d row=%0d ls=%b fs=%b, want 0 0 1 1", col_a, row_a, ls_a, fs_a);
      end
      total++;
      if ({hs_b, vs_b, de_b, r_b, g_b, b_b} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
         bad++;
         $display("FAIL reset_out_b: got hs/vs/de=%b%b%b, want 110", hs_b, vs_b, de_b);
      end
      total++;
      if ({hs_c, vs_c, de_c} !== 3'b000) begin
         bad++;
         $display("FAIL reset_pol_c: got hs/vs/de=%b%b%b, want 000", hs_c, vs_c, de_c);
      end
      $display("reset: hs_a=%b vs_a=%b hs_c=%b vs_c=%b", hs_a, vs_a, hs_c, vs_c);
   endtask

   // Runs ncyc clocks from a fresh reset release, checking the fetch stage against
   // a counter model and the outputs against a latency-aligned expectation queue.
   task automatic test_stream(input int s, input int ncyc);
      int   lat, mh, mv, last_ls, last_fs, hs_run, vs_run, de_run;
      logic pol, act, prev_de, hs_on, vs_on;
      logic [10:0] e_col, e_row;
      exp_t e, got;
      lat = (s == 1) ? 3 : 1;
      pol = (s == 2);
      sel = s;
      exp_q.delete();
      for (int i = 0; i < lat + 1; i++) exp_q.push_back('{~pol, ~pol, 1'b0, 12'h000});
      mh = 0; mv = 0; last_ls = -1; last_fs = -1;
      hs_run = 0; vs_run = 0; de_run = 0; prev_de = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         act   = (mh < HA) && (mv < VA);
         e_col = act ? 11'(mh) : 11'(HA);
         e_row = act ? 11'(mv) : 11'(VA);
         total++;
         if ({obs_col, obs_row, obs_ls, obs_fs} !== {e_col, e_row, mh == 0, mh == 0 && mv == 0}) begin
            bad++;
            $display("FAIL fetch[%0d]: got col=%0d row=%0d ls=%b fs=%b, want col=%0d row=%0d h=%0d v=%0d",
                     s, obs_col, obs_row, obs_ls, obs_fs, e_col, e_row, mh, mv);
         end
         e.de  = act;
         e.hs  = ((mh >= HA + HF) && (mh < HA + HF + HP)) ? pol : ~pol;
         e.vs  = ((mv >= VA + VF) && (mv < VA + VF + VP)) ? pol : ~pol;
         e.rgb = act ? {4'(mh), 4'(mv), 4'(mh)} : 12'h000;
         exp_q.push_back(e);
         if (exp_q.size() > lat + 1) begin
            e   = exp_q.pop_front();
            got = '{obs_hs, obs_vs, obs_de, obs_rgb};
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL out[%0d] n=%0d: got hs=%b vs=%b de=%b rgb=%h, want hs=%b vs=%b de=%b rgb=%h",
                        s, n, got.hs, got.vs, got.de, got.rgb, e.hs, e.vs, e.de, e.rgb);
            end
         end
         if (obs_ls) begin
            if (last_ls >= 0) begin
               total++;
               if (n - last_ls != HW) begin
                  bad++;
                  $display("FAIL line_period[%0d]: got %0d, want %0d", s, n - last_ls, HW);
               end
            end
            last_ls = n;
         end
         if (obs_fs) begin
            if (last_fs >= 0) begin
               total++;
               if (n - last_fs != HW * VW) begin
                  bad++;
                  $display("FAIL frame_period[%0d]: got %0d, want %0d", s, n - last_fs, HW * VW);
               end
            end
            last_fs = n;
         end
         if (obs_de && !prev_de) begin
            total++;
            if (n - last_ls != lat + 1) begin
               bad++;
               $display("FAIL de_rise[%0d]: got %0d after line_start, want %0d", s, n - last_ls, lat + 1);
            end
         end
         hs_on = (obs_hs === pol);
         vs_on = (obs_vs === pol);
         if (hs_on) hs_run++;
         else if (hs_run > 0) begin
            total++;
            if (hs_run != HP) begin
               bad++;
               $display("FAIL hs_width[%0d]: got %0d, want %0d", s, hs_run, HP);
            end
            hs_run = 0;
         end
         if (vs_on) vs_run++;
         else if (vs_run > 0) begin
            total++;
            if (vs_run != VP * HW) begin
               bad++;
               $display("FAIL vs_width[%0d]: got %0d, want %0d", s, vs_run, VP * HW);
            end
            vs_run = 0;
         end
         if (obs_de === 1'b1) de_run++;
         else if (de_run > 0) begin
            total++;
            if (de_run != HA) begin
               bad++;
               $display("FAIL de_width[%0d]: got %0d, want %0d", s, de_run, HA);
            end
            de_run = 0;
         end
         prev_de = (obs_de === 1'b1);
         if (mh == HW - 1) begin
            mh = 0;
            mv = (mv == VW - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
      $display("stream sel=%0d lat=%0d pol=%b cycles=%0d total=%0d bad=%0d", s, lat, pol, ncyc, total, bad);
   endtask

   task automatic test_tiny();
      do_reset();
      test_stream(0, 260);
   endtask

   task automatic test_fetch_lat3();
      do_reset();
      test_stream(1, 260);
   endtask

   task automatic test_polarity();
      do_reset();
      test_stream(2, 260);
   endtask

   task automatic test_mid_reset();
      int waited;
      do_reset();
      sel = 0;
      waited = 0;
      // Move into the second line's hsync pulse before yanking reset.
      repeat (HW) @(negedge clk);
      while (hs_a !== 1'b0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (hs_a !== 1'b0) begin
         bad++;
         $display("FAIL mid_wait: hs_a=%b never went low within 100 clocks", hs_a);
      end
      #2 clrn = 1'b0;
      #1;
      total++;
      if ({hs_a, vs_a, de_a, r_a, g_a, b_a, col_a, row_a, ls_a, fs_a} !==
          {1'b1, 1'b1, 1'b0, 12'h000, 11'd0, 11'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL mid_async: got hs=%b vs=%b de=%b rgb=%h col=%0d row=%0d ls=%b fs=%b, want reset values",
                  hs_a, vs_a, de_a, {b_a, g_a, r_a}, col_a, row_a, ls_a, fs_a);
      end
      $display("mid-pulse reset: hs_a=%b de_a=%b col_a=%0d", hs_a, de_a, col_a);
      do_reset();
      test_stream(0, 130);
   endtask

   initial begin
      test_reset();
      test_tiny();
      test_fetch_lat3();
      test_polarity();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
